// File: rtl/sdram_ch_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller channel among three clients.
// Optional WAIT-state watchdog is compiled in when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_ch_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cl_req,
  input  logic [2:0]  cl_rnw,
  input  logic [80:0] cl_addr,
  input  logic [95:0] cl_din,
  input  logic [11:0] cl_be,
  output logic [2:0]  cl_ready,
  output logic [31:0] cl_dout,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [26:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sdram_ch_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state;
  logic [1:0]  last_grant;
  logic [1:0]  grant;
  logic [2:0]  pending;
  logic [2:0]  cand;
  logic [2:0]  clear_mask;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  order [3];

  logic [26:0] in_addr   [3];
  logic [31:0] in_din    [3];
  logic [3:0]  in_be     [3];
  logic [26:0] hold_addr [3];
  logic [31:0] hold_din  [3];
  logic [3:0]  hold_be   [3];
  logic [2:0]  hold_rnw;

  logic        sel_rnw;
  logic [26:0] sel_addr;
  logic [31:0] sel_din;
  logic [3:0]  sel_be;

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign in_addr[i] = cl_addr[27*i +: 27];
    assign in_din[i]  = cl_din[32*i +: 32];
    assign in_be[i]   = cl_be[4*i +: 4];
  end

  // Each request overwrites its client's holding register, so the last request wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cl_req[i]) begin
        hold_addr[i] <= in_addr[i];
        hold_din[i]  <= in_din[i];
        hold_be[i]   <= in_be[i];
        hold_rnw[i]  <= cl_rnw[i];
      end
    end
  end

  always_comb begin
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd2;
    case (last_grant)
      2'd0: begin
        order[0] = 2'd1;
        order[1] = 2'd2;
        order[2] = 2'd0;
      end
      2'd1: begin
        order[0] = 2'd2;
        order[1] = 2'd0;
        order[2] = 2'd1;
      end
      default: ;
    endcase
  end

  // Same-cycle requests compete with pending ones; scanning backwards leaves the first in order.
  always_comb begin
    cand  = pending | cl_req;
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (cand[order[k]]) begin
        found = 1'b1;
        pick  = order[k];
      end
    end
    clear_mask = (state == ST_IDLE && found) ? (3'b001 << pick) : 3'b000;
  end

  always_comb begin
    sel_rnw  = cl_req[pick] ? cl_rnw[pick]  : hold_rnw[pick];
    sel_addr = cl_req[pick] ? in_addr[pick] : hold_addr[pick];
    sel_din  = cl_req[pick] ? in_din[pick]  : hold_din[pick];
    sel_be   = cl_req[pick] ? in_be[pick]   : hold_be[pick];
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pending    <= 3'b000;
      last_grant <= 2'd2;
      grant      <= 2'd0;
      cl_ready   <= 3'b000;
      cl_dout    <= 32'd0;
      mem_req    <= 1'b0;
      mem_rnw    <= 1'b0;
      mem_addr   <= 27'd0;
      mem_din    <= 32'd0;
      mem_be     <= 4'd0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      pending  <= (pending | cl_req) & ~clear_mask;
      cl_ready <= 3'b000;
      mem_req  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant    <= pick;
            mem_rnw  <= sel_rnw;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            mem_be   <= sel_be;
            mem_req  <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (mem_ready) begin
            cl_dout    <= mem_dout;
            cl_ready   <= 3'b001 << grant;
            last_grant <= grant;
            state      <= ST_IDLE;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (wd_cnt == WdLast) begin
            cl_dout    <= 32'd0;
            cl_ready   <= 3'b001 << grant;
            last_grant <= grant;
            timeout_q  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Self-checking bench for sdram_ch_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model. Define SDRAM_ARB_TIMEOUT_EN to include the watchdog scenario.
`timescale 1ns/1ps
module tb_sdram_ch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cl_req, cl_rnw;
  logic [80:0] cl_addr;
  logic [95:0] cl_din;
  logic [11:0] cl_be;
  logic [2:0]  cl_ready;
  logic [31:0] cl_dout;
  logic        mem_req, mem_rnw;
  logic [26:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_dout;
  logic        busy, timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sdram_ch_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cl_req(cl_req), .cl_rnw(cl_rnw), .cl_addr(cl_addr), .cl_din(cl_din), .cl_be(cl_be),
    .cl_ready(cl_ready), .cl_dout(cl_dout),
    .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_dout(mem_dout),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Round-robin choice straight from the arbitration rule: first pending client after last grant.
  function automatic int rr_pick(input bit [2:0] p, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c = (last + k) % 3;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    cl_req = 3'b000; cl_rnw = 3'b000; cl_addr = '0; cl_din = '0; cl_be = '0;
    mem_ready = 1'b0; mem_dout = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    cl_req = 3'b111;
    cl_addr = {3{27'h1ABCDEF}};
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || cl_ready !== 3'b000 || cl_dout !== 32'd0 ||
        timeout_err !== 1'b0 || mem_addr !== 27'd0 || mem_din !== 32'd0 || mem_be !== 4'd0 || mem_rnw !== 1'b0)
      begin
        tests_failed++;
        $display("[TB] FAIL reset_values: busy=%b mem_req=%b cl_ready=%b cl_dout=%h terr=%b mem_addr=%h expected all zero",
                 busy, mem_req, cl_ready, cl_dout, timeout_err, mem_addr);
      end
    reset = 1'b0;
    cl_req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_req_dropped: mem_req=%b busy=%b expected 0 0", mem_req, busy);
      end
    end
  endtask

  task automatic test_single_read();
    int pulses = 0;
    do_reset();
    @(negedge clk);
    cl_req = 3'b010; cl_rnw = 3'b010; cl_addr[27 +: 27] = 27'h0000100;
    @(negedge clk);
    cl_req = 3'b000; cl_addr = '1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 27'h0000100 || mem_rnw !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_read_issue: mem_req=%b addr=%h rnw=%b busy=%b expected 1 0000100 1 1",
               mem_req, mem_addr, mem_rnw, busy);
    end
    if (mem_req === 1'b1) pulses++;
    mem_ready = 1'b1; mem_dout = 32'hBAD0BAD0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) pulses++;
      tests_run++;
      if (cl_ready !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL single_read_early_ready: cycle %0d cl_ready=%b expected 000", i, cl_ready);
      end
      mem_ready = (i == 12);
      mem_dout = (i == 12) ? 32'hDEADBEEF : 32'h0BADF00D;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    tests_run++;
    if (cl_ready !== 3'b010 || cl_dout !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL single_read_ready: cl_ready=%b cl_dout=%h expected 010 deadbeef", cl_ready, cl_dout);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 1 || cl_ready !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_read_once: pulses=%0d cl_ready=%b busy=%b expected 1 000 0", pulses, cl_ready, busy);
    end
  endtask

  task automatic test_write();
    do_reset();
    @(negedge clk);
    cl_req = 3'b100; cl_rnw = 3'b011;
    cl_addr = {27'h05A5A5A, 27'h1111111, 27'h2222222};
    cl_din = {32'h12345678, 32'hCAFEF00D, 32'h87654321};
    cl_be = {4'b0011, 4'b1111, 4'b1111};
    @(negedge clk);
    clear_inputs();
    tests_run++;
    if (mem_req !== 1'b1 || mem_rnw !== 1'b0 || mem_din !== 32'h12345678 || mem_be !== 4'b0011 ||
        mem_addr !== 27'h05A5A5A) begin
      tests_failed++;
      $display("[TB] FAIL write_issue: req=%b rnw=%b din=%h be=%b addr=%h expected 1 0 12345678 0011 05a5a5a",
               mem_req, mem_rnw, mem_din, mem_be, mem_addr);
    end
    repeat (3) @(negedge clk);
    mem_ready = 1'b1; mem_dout = 32'h00000000;
    @(negedge clk);
    mem_ready = 1'b0;
    tests_run++;
    if (cl_ready !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL write_ready: cl_ready=%b expected 100", cl_ready);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0, last_req = -100, due = -1, exp_cl = -1, chk = -1;
    do_reset();
    @(negedge clk);
    cl_req = 3'b111; cl_rnw = 3'b111;
    for (int i = 0; i < 3; i++) cl_addr[27*i +: 27] = 27'(32'h1000 * (i + 1));
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      cl_req = 3'b000; mem_ready = 1'b0;
      if (cyc == chk) begin
        tests_run++;
        if (cl_ready !== (3'b001 << exp_cl) || cl_dout !== 32'hA0000000 + 32'(exp_cl)) begin
          tests_failed++;
          $display("[TB] FAIL simul_ready: cl_ready=%b dout=%h expected client %0d", cl_ready, cl_dout, exp_cl);
        end
      end
      if (mem_req === 1'b1) begin
        if (n < 3) begin
          tests_run++;
          if (mem_addr !== 27'(32'h1000 * (n + 1))) begin
            tests_failed++;
            $display("[TB] FAIL simul_order: grant %0d addr=%h expected %h", n, mem_addr, 27'(32'h1000 * (n + 1)));
          end
        end
        if (n > 0) begin
          tests_run++;
          if (cyc - last_req < 3) begin
            tests_failed++;
            $display("[TB] FAIL simul_spacing: gap=%0d expected at least 3", cyc - last_req);
          end
        end
        exp_cl = n; last_req = cyc; due = cyc + 1; n++;
      end
      if (cyc == due) begin
        mem_ready = 1'b1; mem_dout = 32'hA0000000 + 32'(exp_cl); chk = cyc + 1;
      end
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("[TB] FAIL simul_count: mem_req pulses=%0d expected 3", n);
    end
  endtask

  task automatic test_fairness();
    int n = 0, due = -1;
    bit rereq = 0;
    logic [26:0] seq [3];
    for (int i = 0; i < 3; i++) seq[i] = '0;
    do_reset();
    @(negedge clk);
    cl_req = 3'b001; cl_addr[0 +: 27] = 27'h00AAAA0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      cl_req = 3'b000; mem_ready = 1'b0;
      if (cyc == 2) begin cl_req[2] = 1'b1; cl_addr[54 +: 27] = 27'h00CCCC2; end
      if (cl_ready[0] === 1'b1 && !rereq) begin
        cl_req[0] = 1'b1; cl_addr[0 +: 27] = 27'h00BBBB0; rereq = 1;
      end
      if (mem_req === 1'b1) begin
        if (n < 3) seq[n] = mem_addr;
        n++; due = cyc + 2;
      end
      if (cyc == due) mem_ready = 1'b1;
    end
    tests_run++;
    if (n != 3 || seq[0] !== 27'h00AAAA0 || seq[1] !== 27'h00CCCC2 || seq[2] !== 27'h00BBBB0) begin
      tests_failed++;
      $display("[TB] FAIL fairness_order: n=%0d seq=%h %h %h expected 3 00aaaa0 00cccc2 00bbbb0",
               n, seq[0], seq[1], seq[2]);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    @(negedge clk);
    cl_req = 3'b010; cl_addr[27 +: 27] = 27'h0000777;
    @(negedge clk);
    cl_req = 3'b000;
    @(negedge clk);
    cl_req = 3'b101;
    @(negedge clk);
    cl_req = 3'b000; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; mem_dout = 32'h55AA55AA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      tests_run++;
      if (cl_ready !== 3'b000 || busy !== 1'b0 || mem_req !== 1'b0 || timeout_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_in_wait: cl_ready=%b busy=%b mem_req=%b terr=%b expected 000 0 0 0",
                 cl_ready, busy, mem_req, timeout_err);
      end
    end
  endtask

  task automatic test_random();
    bit [2:0]    pend = 3'b000;
    logic [26:0] m_addr [3];
    logic [31:0] m_din  [3];
    logic [3:0]  m_be   [3];
    bit          m_rnw  [3];
    int last = 2, inflight = -1, issue_cyc = -100, due = -1, chk = -1, last_req = -100;
    int served = 0, issued = 0, pk;
    logic [31:0] exp_dout = '0;
    do_reset();
    for (int cyc = 0; cyc < 2100; cyc++) begin
      @(negedge clk);
      cl_req = 3'b000; mem_ready = 1'b0;
      tests_run++;
      if (cyc == chk) begin
        if (cl_ready !== (3'b001 << inflight) || cl_dout !== exp_dout) begin
          tests_failed++;
          $display("[TB] FAIL rand_ready: cyc %0d cl_ready=%b dout=%h expected client %0d dout %h",
                   cyc, cl_ready, cl_dout, inflight, exp_dout);
        end
        last = inflight; inflight = -1; served++;
      end else if (cl_ready !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL rand_spurious_ready: cyc %0d cl_ready=%b expected 000", cyc, cl_ready);
      end
      if (mem_req === 1'b1) begin
        pk = rr_pick(pend, last);
        tests_run++;
        if (inflight != -1 || pk < 0 || cyc - last_req < 3) begin
          tests_failed++;
          $display("[TB] FAIL rand_issue: cyc %0d inflight=%0d pick=%0d gap=%0d", cyc, inflight, pk, cyc - last_req);
        end else begin
          tests_run++;
          if (mem_addr !== m_addr[pk] || mem_din !== m_din[pk] || mem_be !== m_be[pk] || mem_rnw !== m_rnw[pk]) begin
            tests_failed++;
            $display("[TB] FAIL rand_fields: cyc %0d got %h/%h/%b/%b expected client %0d %h/%h/%b/%b", cyc,
                     mem_addr, mem_din, mem_be, mem_rnw, pk, m_addr[pk], m_din[pk], m_be[pk], m_rnw[pk]);
          end
          pend[pk] = 1'b0; inflight = pk; issue_cyc = cyc; issued++;
          due = cyc + int'($urandom_range(1, 6));
        end
        last_req = cyc;
      end
      tests_run++;
      if (busy !== (inflight != -1) || timeout_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand_busy: cyc %0d busy=%b terr=%b expected %b 0", cyc, busy, timeout_err, inflight != -1);
      end
      if (inflight != -1 && cyc == due) begin
        exp_dout = $urandom; mem_ready = 1'b1; mem_dout = exp_dout; chk = cyc + 1;
      end else if ((inflight == -1 || cyc == issue_cyc) && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1; mem_dout = $urandom;
      end
      if (cyc < 2000) begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            m_addr[i] = 27'($urandom); m_din[i] = $urandom; m_be[i] = 4'($urandom); m_rnw[i] = 1'($urandom);
            cl_req[i] = 1'b1; cl_rnw[i] = m_rnw[i];
            cl_addr[27*i +: 27] = m_addr[i]; cl_din[32*i +: 32] = m_din[i]; cl_be[4*i +: 4] = m_be[i];
            pend[i] = 1'b1;
          end
        end
      end
    end
    tests_run++;
    if (pend != 3'b000 || inflight != -1 || served != issued || issued == 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain: pend=%b inflight=%0d served=%0d issued=%0d", pend, inflight, served, issued);
    end
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t_req = -1, t_rdy = -1;
    do_reset();
    mem_dout = 32'hFFFFFFFF;
    @(negedge clk);
    cl_req = 3'b001; cl_addr[0 +: 27] = 27'h0000123;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      cl_req = 3'b000;
      if (mem_req === 1'b1 && t_req < 0) t_req = cyc;
      if (cl_ready !== 3'b000 && t_rdy < 0) begin
        t_rdy = cyc;
        tests_run++;
        if (cl_ready !== 3'b001 || cl_dout !== 32'd0) begin
          tests_failed++;
          $display("[TB] FAIL timeout_ready: cl_ready=%b dout=%h expected 001 00000000", cl_ready, cl_dout);
        end
      end
    end
    tests_run++;
    if (t_req < 0 || t_rdy < 0 || t_rdy - t_req < 15 || t_rdy - t_req > 18) begin
      tests_failed++;
      $display("[TB] FAIL timeout_latency: req at %0d ready at %0d expected 15..18 apart", t_req, t_rdy);
    end
    tests_run++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_sticky: terr=%b busy=%b expected 1 0", timeout_err, busy);
    end
    do_reset();
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_clear: terr=%b expected 0", timeout_err);
    end
  endtask
`endif

  initial begin
    #500000;
    tests_failed++;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_simultaneous();
    test_fairness();
    test_reset_in_wait();
    test_random();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
